axi4_lite_slave_regs: RTL and testbench
=======================================

AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width; only 32 supported.
REQ-003 SHALL have parameter REG_NUM, default 16, number of 32-bit registers; 1..64.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have write address ports: s_awaddr  in  ADDR_WIDTH  write address; s_awvalid  in  1; s_awready  out  1.
REQ-006 SHALL have write data ports: s_wdata  in  32; s_wstrb  in  4  byte strobes; s_wvalid  in  1; s_wready  out  1.
REQ-007 SHALL have write response ports: s_bresp  out  2; s_bvalid  out  1; s_bready  in  1.
REQ-008 SHALL have read address ports: s_araddr  in  ADDR_WIDTH; s_arvalid  in  1; s_arready  out  1.
REQ-009 SHALL have read data ports: s_rdata  out  32; s_rresp  out  2; s_rvalid  out  1; s_rready  in  1.

Function
REQ-010 SHALL decode register index = addr[7:2]; addr[1:0] ignored; index >= REG_NUM is out-of-range.
REQ-011 SHALL ignore address bits above bit 7 (the interconnect decodes 256-byte slave windows).
REQ-012 Write FSM states SHALL be W_IDLE, W_GOTADDR, W_GOTDATA and W_RESP.
REQ-013 s_awready SHALL be 1 in W_IDLE and W_GOTDATA; s_wready SHALL be 1 in W_IDLE and W_GOTADDR; both SHALL be 0 in W_RESP.
REQ-014 W_IDLE: AW and W handshake in the same cycle -> W_RESP; AW only -> W_GOTADDR with address latched; W only -> W_GOTDATA with data and strobe latched.
REQ-015 W_GOTADDR on W handshake -> W_RESP; W_GOTDATA on AW handshake -> W_RESP.
REQ-016 The register write SHALL take effect on the clock edge that completes the AW/W pair.
REQ-017 Byte lane i SHALL be written only if wstrb[i]=1; wstrb=0 leaves the register unchanged but still returns a response.
REQ-018 s_bvalid SHALL assert in the cycle after the pair completes and hold, with s_bresp stable, until s_bready=1; the FSM then returns to W_IDLE.
REQ-019 Read FSM states SHALL be R_IDLE (s_arready=1) and R_DATA (s_arready=0, s_rvalid=1).
REQ-020 On an AR handshake the block SHALL register s_rdata/s_rresp from the register value before that edge; rvalid asserts the next cycle (1-cycle latency).
REQ-021 s_rdata and s_rresp SHALL hold stable until s_rready=1, then return to R_IDLE; no new AR is accepted in the handshake cycle.
REQ-022 Read and write channels SHALL be independent and concurrent; a read and a write to the same register completing on the same edge SHALL return the old value.
REQ-023 An in-range access SHALL return resp 2'b00 (OKAY).
REQ-024 When s_rvalid=0, s_rdata SHALL be 0.

Reset
REQ-025 With rst_n=0 at a rising edge, all registers, s_bvalid, s_rvalid, s_rdata, s_bresp and s_rresp SHALL be 0 and both FSMs SHALL be idle.
REQ-026 After reset, s_awready, s_wready and s_arready SHALL be 1.
REQ-027 Reset mid-transaction SHALL abort it silently: no response, and a partially latched AW or W is discarded.

Configuration
REQ-028 With macro AXI4L_SLV_ERR_RESP_EN defined, an out-of-range write SHALL be dropped with bresp=2'b10 (SLVERR), and an out-of-range read SHALL return rdata=0 with rresp=2'b10.
REQ-029 Without AXI4L_SLV_ERR_RESP_EN, out-of-range writes SHALL be dropped and reads SHALL return 0, both with resp=2'b00; the handshake timing is identical in both builds.

Structure
REQ-030 Package axi4_lite_pkg SHALL hold the response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 and the write/read FSM state enums.
REQ-031 Sub-module axi4_lite_regfile SHALL implement the REG_NUM x 32 storage, the byte-strobe write port and one combinational read port; handshake logic stays in the top.

Verification
REQ-032 Reset, then AW+W in one cycle, addr 0x04, data 0xAABBCCDD, strb 4'hF -> bvalid the next cycle with bresp=00; AR 0x04 -> rdata=0xAABBCCDD, rresp=00.
REQ-033 AW 0x08 three cycles before W 0xDEADBEEF, then a second case with W 0x12345678 before AW 0x0C -> both written; readback returns 0xDEADBEEF and 0x12345678.
REQ-034 Write 0xFFFFFFFF to 0x10, then write 0x00000000 with strb 4'b0101 -> readback 0xFF00FF00.
REQ-035 Hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid, rdata and resp stay stable, and awready, wready and arready stay 0 until release.
REQ-036 Same-edge write 0x11111111 and read of 0x14 when it holds 0x22222222 -> read returns 0x22222222; a following read returns 0x11111111.
REQ-037 With REG_NUM=16, write and read 0x40 -> resp 10 and rdata 0 with the macro defined; resp 00 and rdata 0 without it; no register changes in either build.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared response codes, FSM state types and address-decode helper for the
// AXI4-Lite register slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOTADDR,
    W_GOTDATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic logic idx_in_range(input logic [5:0] idx, input int unsigned num);
    return {26'd0, idx} < num;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// REG_NUM x DATA_WIDTH register storage with one byte-strobed write port and
// one combinational read port.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int REG_NUM    = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [5:0]              wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic [5:0]              rd_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [REG_NUM-1:0]    wr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_hit
      assign wr_hit[gi] = wr_en_i && (wr_idx_i == 6'(gi));
    end
  endgenerate

  // Registers must clear on reset, so this is flop storage rather than a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_hit[i] && wr_strb_i[b]) regs_q[i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd_idx_i == 6'(i)) rd_data_o = regs_q[i];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing REG_NUM 32-bit registers in a 256-byte window.
// Define AXI4L_SLV_ERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

`ifdef AXI4L_SLV_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  wstate_e                 w_state_q, w_state_d;
  logic [5:0]              awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  rstate_e                 r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs, pair_done, wr_en;
  logic [5:0]              wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data, reg_rdata;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    unused_addr_bits;

  // The interconnect decodes everything above bit 7; bits [1:0] are byte offsets.
  assign unused_addr_bits = ^{s_awaddr[ADDR_WIDTH-1:8], s_awaddr[1:0],
                              s_araddr[ADDR_WIDTH-1:8], s_araddr[1:0]};

  assign s_awready = (w_state_q == W_IDLE) || (w_state_q == W_GOTDATA);
  assign s_wready  = (w_state_q == W_IDLE) || (w_state_q == W_GOTADDR);
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = (r_state_q == R_IDLE);
  assign s_rvalid  = (r_state_q == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  always_comb begin
    w_state_d = w_state_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    pair_done = 1'b0;
    wr_idx    = awidx_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          pair_done = 1'b1;
          wr_idx    = s_awaddr[7:2];
          wr_data   = s_wdata;
          wr_strb   = s_wstrb;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          awidx_d   = s_awaddr[7:2];
          w_state_d = W_GOTADDR;
        end else if (w_hs) begin
          wdata_d   = s_wdata;
          wstrb_d   = s_wstrb;
          w_state_d = W_GOTDATA;
        end
      end
      W_GOTADDR: begin
        if (w_hs) begin
          pair_done = 1'b1;
          wr_data   = s_wdata;
          wr_strb   = s_wstrb;
          w_state_d = W_RESP;
        end
      end
      W_GOTDATA: begin
        if (aw_hs) begin
          pair_done = 1'b1;
          wr_idx    = s_awaddr[7:2];
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    wr_en = pair_done && idx_in_range(wr_idx, REG_NUM);
    if (pair_done) bresp_d = idx_in_range(wr_idx, REG_NUM) ? RESP_OKAY : OOR_RESP;
  end

  // rdata is forced to zero whenever rvalid is low.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = idx_in_range(s_araddr[7:2], REG_NUM) ? reg_rdata : '0;
          rresp_d   = idx_in_range(s_araddr[7:2], REG_NUM) ? RESP_OKAY : OOR_RESP;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          r_state_d = R_IDLE;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  axi4_lite_regfile #(
    .REG_NUM   (REG_NUM),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_data_i(wr_data),
    .wr_strb_i(wr_strb),
    .rd_idx_i (s_araddr[7:2]),
    .rd_data_o(reg_rdata)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed cases plus randomized
// traffic compared against an array-based register model.
module tb_axi4_lite_slave_regs;

  localparam int NREG = 16;

`ifdef AXI4L_SLV_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  logic [31:0] model [NREG];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    return res;
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'(addr[7:2]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return (idx_of(addr) < NREG) ? model[idx_of(addr)] : 32'd0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
    return (idx_of(addr) < NREG) ? 2'b00 : OOR_RESP;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (idx_of(addr) < NREG) model[idx_of(addr)] = merge(model[idx_of(addr)], data, strb);
  endtask

  task automatic finish_write(input logic [31:0] addr, input int hold);
    chk("bvalid_after_pair", 32'(s_bvalid), 32'd1);
    chk("bresp", 32'(s_bresp), 32'(exp_resp(addr)));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bvalid_hold", 32'(s_bvalid), 32'd1);
      chk("bresp_hold", 32'(s_bresp), 32'(exp_resp(addr)));
      chk("aw_w_ready_hold", {30'd0, s_awready, s_wready}, 32'd0);
    end
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("bvalid_release", 32'(s_bvalid), 32'd0);
    chk("aw_w_ready_idle", {30'd0, s_awready, s_wready}, 32'd3);
  endtask

  // mode 0: AW and W together; 1: AW first; 2: W first. gap = idle cycles between.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int mode, input int gap, input int hold);
    s_awaddr = addr;
    s_wdata  = data;
    s_wstrb  = strb;
    chk("ready_before_write", {30'd0, s_awready, s_wready}, 32'd3);
    if (mode == 0) begin
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      step();
    end else begin
      if (mode == 1) s_awvalid = 1'b1; else s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      for (int g = 0; g < gap; g++) begin
        chk("bvalid_half_pair", 32'(s_bvalid), 32'd0);
        chk("ready_half_pair", {30'd0, s_awready, s_wready}, (mode == 1) ? 32'd1 : 32'd2);
        s_wdata  = $urandom;
        s_awaddr = $urandom;
        step();
      end
      s_awaddr = addr;
      s_wdata  = data;
      if (mode == 1) s_wvalid = 1'b1; else s_awvalid = 1'b1;
      step();
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    model_write(addr, data, strb);
    finish_write(addr, hold);
  endtask

  // arvalid stays high through the release cycle to confirm no AR is taken then.
  task automatic do_read(input logic [31:0] addr, input int hold);
    logic [31:0] exp = model_read(addr);
    s_araddr  = addr;
    s_arvalid = 1'b1;
    chk("arready_idle", 32'(s_arready), 32'd1);
    step();
    chk("rvalid", 32'(s_rvalid), 32'd1);
    chk($sformatf("rdata@%08h", addr), s_rdata, exp);
    chk("rresp", 32'(s_rresp), 32'(exp_resp(addr)));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("rvalid_hold", 32'(s_rvalid), 32'd1);
      chk("rdata_hold", s_rdata, exp);
      chk("rresp_hold", 32'(s_rresp), 32'(exp_resp(addr)));
      chk("arready_hold", 32'(s_arready), 32'd0);
    end
    s_rready = 1'b1;
    step();
    s_rready  = 1'b0;
    s_arvalid = 1'b0;
    chk("rvalid_release", 32'(s_rvalid), 32'd0);
    chk("rdata_idle_zero", s_rdata, 32'd0);
    chk("arready_release", 32'(s_arready), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    chk("rst_bvalid_rvalid", {30'd0, s_bvalid, s_rvalid}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a, d;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    apply_reset();

    do_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_read(32'h04, 0);

    do_write(32'h08, 32'hDEADBEEF, 4'hF, 1, 3, 0);
    do_write(32'h0C, 32'h12345678, 4'hF, 2, 3, 0);
    do_read(32'h08, 0);
    do_read(32'h0C, 0);

    do_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h10, 32'h00000000, 4'b0101, 0, 0, 0);
    chk("strobe_model", model[4], 32'hFF00FF00);
    do_read(32'h10, 0);

    do_write(32'h1C, 32'h5A5AA5A5, 4'hF, 0, 0, 5);
    do_read(32'h1C, 5);

    // Write and read of the same register complete on the same edge.
    do_write(32'h14, 32'h22222222, 4'hF, 0, 0, 0);
    s_awaddr = 32'h14; s_wdata = 32'h11111111; s_wstrb = 4'hF; s_araddr = 32'h14;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("same_edge_rdata", s_rdata, 32'h22222222);
    chk("same_edge_bvalid", 32'(s_bvalid), 32'd1);
    model_write(32'h14, 32'h11111111, 4'hF);
    s_bready = 1; s_rready = 1;
    step();
    s_bready = 0; s_rready = 0;
    do_read(32'h14, 0);

    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(32'h40, 0);
    do_read(32'hFFFF_FF06, 1);

    for (int it = 0; it < 80; it++) begin
      a = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(a, d, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end
    for (int i = 0; i < NREG; i++) do_read(32'(i) << 2, 0);

    // Reset with only AW latched; a following lone W must not complete a pair.
    do_write(32'h00, 32'h0BADF00D, 4'hF, 0, 0, 0);
    s_awaddr = 32'h00; s_awvalid = 1;
    step();
    s_awvalid = 0;
    apply_reset();
    do_write(32'h18, 32'h600DCAFE, 4'hF, 2, 2, 0);
    do_read(32'h00, 0);
    do_read(32'h18, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
